// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: PC handshake, instruction-memory request/ack and decode-side queue head.
// The master modport is the fetch queue itself; slave is the surrounding pipeline and memory.
interface if_fetch_queue_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        fetch_ready;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_4_out;

    modport master (
        input  pc_in, pc_valid, redirect, imem_ack, imem_rdata, stall,
        output fetch_ready, imem_req, imem_addr, inst_valid, inst_out, pc_4_out
    );

    modport slave (
        output pc_in, pc_valid, redirect, imem_ack, imem_rdata, stall,
        input  fetch_ready, imem_req, imem_addr, inst_valid, inst_out, pc_4_out
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: one outstanding imem request at a time feeding a DEPTH-entry FIFO
// of {pc+4, instruction}; redirect flushes the FIFO and drops any in-flight response.
module if_fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    if_fetch_queue_if.master bus_io
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e          state_q;
    logic            req_q;
    logic [31:0]     addr_q;
    logic [31:0]     tag_q;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     mem_inst_q [DEPTH];
    logic [31:0]     mem_pc4_q  [DEPTH];

    logic            valid_q, valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [31:0]     pc4_q, pc4_d;

    logic            fetch_ready;
    logic            accept;
    logic            push;
    logic            pop;
    logic            head_fwd;

    // Accepts only happen with no request in flight, so count<DEPTH here reserves the slot
    // the eventual response will occupy.
    assign fetch_ready = (state_q == StIdle) && (count_q < CntW'(DEPTH)) && !bus_io.redirect;
    assign accept      = bus_io.pc_valid && fetch_ready;
    assign push        = (state_q == StWait) && bus_io.imem_ack && !bus_io.redirect;
    assign pop         = valid_q && !bus_io.stall && !bus_io.redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            addr_q  <= '0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StWait;
                        req_q   <= 1'b1;
                        addr_q  <= {bus_io.pc_in[31:2], 2'b00};
                        tag_q   <= bus_io.pc_in + 32'd4;
                    end
                end
                StWait: begin
                    if (bus_io.imem_ack) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end else if (bus_io.redirect) begin
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (bus_io.imem_ack) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus_io.redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // The next head is the entry being written this edge when it lands at the new read pointer.
    always_comb begin
        head_fwd = push && (rd_ptr_d == wr_ptr_q);
        valid_d  = (count_d != '0);
        inst_d   = inst_q;
        pc4_d    = pc4_q;
        if (valid_d) begin
            inst_d = head_fwd ? bus_io.imem_rdata : mem_inst_q[rd_ptr_d];
            pc4_d  = head_fwd ? tag_q : mem_pc4_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst_q[wr_ptr_q] <= bus_io.imem_rdata;
            mem_pc4_q[wr_ptr_q]  <= tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            inst_q   <= '0;
            pc4_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            inst_q   <= inst_d;
            pc4_q    <= pc4_d;
        end
    end

    assign bus_io.fetch_ready = fetch_ready;
    assign bus_io.imem_req    = req_q;
    assign bus_io.imem_addr   = addr_q;
    assign bus_io.inst_valid  = valid_q;
    assign bus_io.inst_out    = inst_q;
    assign bus_io.pc_4_out    = pc4_q;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus random traffic against a queue-level model;
// expectations are queued by the driver and consumed by an independent negedge monitor.
module tb_if_fetch_queue;
    localparam int unsigned DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    if_fetch_queue_if bus ();

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } entry_t;

    typedef struct packed {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
    } ctrl_t;

    entry_t      model_q [$];
    entry_t      sb_q    [$];
    ctrl_t       ctrl_q  [$];
    logic        m_busy  = 1'b0;
    logic        m_drop  = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_tag   = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    ctrl_t       mon_c;
    entry_t      mon_e;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of inputs and advance the model across the coming edge.
    task automatic apply(input logic pcv, input logic [31:0] pc, input logic rd,
                         input logic st, input logic ack, input logic [31:0] rdata);
        ctrl_t c;
        logic  ready;
        bus.pc_valid   = pcv;
        bus.pc_in      = pc;
        bus.redirect   = rd;
        bus.stall      = st;
        bus.imem_ack   = ack;
        bus.imem_rdata = rdata;

        ready   = !m_busy && (model_q.size() < DEPTH) && !rd;
        c.ready = ready;
        c.req   = m_busy;
        c.addr  = m_addr;
        c.valid = (model_q.size() != 0);
        ctrl_q.push_back(c);

        if (model_q.size() != 0 && !st && !rd) sb_q.push_back(model_q.pop_front());
        if (rd) model_q.delete();
        if (m_busy && ack) begin
            if (!m_drop && !rd) model_q.push_back('{pc4: m_tag, inst: rdata});
            m_busy = 1'b0;
            m_drop = 1'b0;
        end else if (m_busy && rd) begin
            m_drop = 1'b1;
        end
        if (pcv && ready) begin
            m_busy = 1'b1;
            m_addr = {pc[31:2], 2'b00};
            m_tag  = pc + 32'd4;
        end
    endtask

    task automatic step(input logic pcv, input logic [31:0] pc, input logic rd,
                        input logic st, input logic ack, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        apply(pcv, pc, rd, st, ack, rdata);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        bus.pc_valid   = 1'b0;
        bus.redirect   = 1'b0;
        bus.stall      = 1'b0;
        bus.imem_ack   = 1'b0;
        #1;
        check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'd0);
        check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_inst_out", bus.inst_out, 32'd0);
        check("rst_pc_4_out", bus.pc_4_out, 32'd0);
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_addr = '0;
        m_tag  = '0;
        model_q.delete();
        ctrl_q.delete();
        @(posedge clk);
        #1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // A stale ack right after release must not write the queue.
        apply(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hBAD1BAD1);
    endtask

    always @(negedge clk) begin
        if (rst_n && ctrl_q.size() != 0) begin
            mon_c = ctrl_q.pop_front();
            check("fetch_ready", {31'd0, bus.fetch_ready}, {31'd0, mon_c.ready});
            check("imem_req", {31'd0, bus.imem_req}, {31'd0, mon_c.req});
            check("imem_addr", bus.imem_addr, mon_c.addr);
            check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, mon_c.valid});
            if (bus.inst_valid && !bus.stall && !bus.redirect) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL issue: got inst %08h, expected no issue at %0t",
                             bus.inst_out, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("inst_out", bus.inst_out, mon_e.inst);
                    check("pc_4_out", bus.pc_4_out, mon_e.pc4);
                end
            end
        end
    end

    initial begin
        bus.pc_valid   = 1'b0;
        bus.pc_in      = '0;
        bus.redirect   = 1'b0;
        bus.stall      = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        do_reset();

        // Basic fetch with a two-cycle memory latency.
        step(1'b1, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h8C08_0004);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Fill under stall, then drain in order.
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'(4 * i), 1'b0, 1'b1, m_busy, 32'h1000 + 32'(i));
        for (int i = 0; i < 6; i++)
            step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Redirect while waiting: flush, drop the late response, refetch 0x200.
        step(1'b1, 32'h0000_000C, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1111_2222);
        step(1'b1, 32'h0000_0010, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0AAA);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Redirect coinciding with ack.
        step(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h3333_3333);
        step(1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h4444_4444);

        // Address wrap and misaligned PC.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h5555_5555);
        step(1'b1, 32'h0040_0002, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h6666_6666);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Reset in the middle of a request.
        step(1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        do_reset();
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hBAD2BAD2);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, $urandom, ($urandom % 16) == 0, ($urandom % 3) == 0,
                 ($urandom % 3) == 0, $urandom);

        for (int i = 0; i < 12; i++)
            step(1'b0, 32'd0, 1'b0, 1'b0, m_busy, 32'h7777_0000 + 32'(i));
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("model_drained", 32'(model_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, which is the number of instruction queue entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port pc_in, input, 32 bits: fetch address offered by the PC register.
REQ-005 The block SHALL have port pc_valid, input, 1 bit: pc_in is valid this cycle.
REQ-006 The block SHALL have port fetch_ready, output, 1 bit: the block accepts pc_in this cycle; the PC register advances only when this is high.
REQ-007 The block SHALL have port redirect, input, 1 bit: a taken branch, jump, jal or jr; flushes all fetched-but-unissued work.
REQ-008 The block SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-009 The block SHALL have port imem_addr, output, 32 bits: word-aligned request address.
REQ-010 The block SHALL have port imem_ack, input, 1 bit: the memory completes the request this cycle.
REQ-011 The block SHALL have port imem_rdata, input, 32 bits: instruction word, valid only while imem_ack is high.
REQ-012 The block SHALL have port stall, input, 1 bit: load-use hazard; the decode stage does not consume this cycle.
REQ-013 The block SHALL have port inst_valid, output, 1 bit: the queue head is valid.
REQ-014 The block SHALL have port inst_out, output, 32 bits: the queue-head instruction.
REQ-015 The block SHALL have port pc_4_out, output, 32 bits: the queue-head fetch address + 4, mod 2^32.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and DROP, encoded in a registered state variable.
REQ-017 fetch_ready SHALL be high iff all three hold: state==IDLE, count<DEPTH, and redirect==0.
REQ-018 Accept (pc_valid&&fetch_ready at edge N) SHALL register imem_addr={pc_in[31:2],2'b00}, store pc_in+4 as the tag, and enter WAIT; imem_req is high from cycle N+1.
REQ-019 In WAIT, imem_req SHALL stay high and imem_addr SHALL stay stable until imem_ack is sampled high; only one request may be outstanding.
REQ-020 imem_ack in WAIT without redirect SHALL write {tag, imem_rdata} to the queue tail and return the FSM to IDLE; inst_valid reflects the entry on the next cycle.
REQ-021 A slot SHALL be reserved at accept time, so a write on ack never overflows, even when no pop occurs.
REQ-022 Pop SHALL occur when inst_valid && !stall; the head advances at the edge.
REQ-023 A simultaneous push and pop SHALL leave count unchanged; read and write pointers wrap modulo DEPTH.
REQ-024 redirect SHALL clear the queue (count=0, pointers equal) at that edge; no pop is counted that cycle.
REQ-025 redirect in WAIT without imem_ack SHALL move the FSM to DROP; imem_req stays high with an unchanged address until ack.
REQ-026 redirect coinciding with imem_ack in WAIT SHALL discard the data and move the FSM to IDLE.
REQ-027 In DROP, imem_ack SHALL discard the data and move the FSM to IDLE; further redirects in DROP keep the FSM in DROP.
REQ-028 imem_ack outside WAIT/DROP SHALL be ignored.
REQ-029 inst_out and pc_4_out SHALL be undefined-safe: they hold the last head value when inst_valid==0.

Reset
REQ-030 When rst_n is low, the block SHALL asynchronously set state=IDLE, count=0, pointers=0, imem_req=0, imem_addr=0, inst_valid=0, inst_out=0 and pc_4_out=0.
REQ-031 Reset asserted mid-request SHALL abandon the request; after reset the block SHALL ignore a stale imem_ack.
REQ-032 fetch_ready SHALL be high in the first cycle after rst_n deasserts.

Verification
REQ-033 Scenario 1: pc_in=0x00400000 accepted; imem_ack after 2 cycles with rdata=0x8C080004 -> inst_valid=1, inst_out=0x8C080004, pc_4_out=0x00400004.
REQ-034 Scenario 2: stall=1 for 8 cycles while PCs 0x0,0x4,0x8,... are offered -> exactly 4 entries queued, fetch_ready=0, imem_req=0; then stall=0 -> entries drain in order.
REQ-035 Scenario 3: redirect while WAIT on 0x10 (no ack) -> queue empties and the FSM enters DROP; ack with rdata=0xDEADBEEF -> no inst_valid; the next accept of 0x200 fetches 0x200.
REQ-036 Scenario 4: redirect and imem_ack in the same cycle -> data discarded, FSM IDLE, fetch_ready=1 the following cycle.
REQ-037 Scenario 5: pc_in=0xFFFFFFFC -> pc_4_out=0x00000000; pc_in=0x00400002 -> imem_addr=0x00400000.
REQ-038 Scenario 6: rst_n pulled low during WAIT -> all outputs 0 immediately; a following ack pulse -> no queue write.
